// File: rtl/z80_bus_master_pkg.sv
// Shared definitions for the Z80 bus master: bus cycle state encodings, strobe
// active levels, default bus widths and a counter-width helper.
package z80_bus_master_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StT1,
      StT2,
      StTw,
      StT3
   } bus_state_e;

   // Z80 strobes are active low.
   localparam logic StrobeOn  = 1'b0;
   localparam logic StrobeOff = 1'b1;

   localparam int unsigned DefAddrW     = 16;
   localparam int unsigned DefDataW     = 8;
   localparam int unsigned DefTstateDiv = 4;

   // Bits needed to hold values 0..v-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/z80_bus_master_timer.sv
// T-state phase timer: counts clk cycles 0..Div-1 within the current T-state.
//   clk_i   system clock
//   rst_i   synchronous active-high reset
//   clr_i   restart at phase 0 (bus cycle accepted)
//   en_i    advance the phase (a bus cycle is in progress)
//   phase_o current phase
//   half_o  phase in the second half of the T-state
//   last_o  final clk of the T-state
module z80_bus_master_timer
   import z80_bus_master_pkg::*;
#(
   parameter int unsigned Div = DefTstateDiv,
   parameter int unsigned PhW = 2
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clr_i,
   input  logic           en_i,
   output logic [PhW-1:0] phase_o,
   output logic           half_o,
   output logic           last_o
);

   logic [PhW-1:0] phase_q, phase_d;

   assign phase_o = phase_q;
   assign half_o  = (phase_q >= PhW'(Div / 2));
   assign last_o  = (phase_q == PhW'(Div - 1));

   always_comb begin
      phase_d = phase_q;
      if (clr_i) begin
         phase_d = '0;
      end else if (en_i) begin
         phase_d = last_o ? '0 : phase_q + PhW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/z80_bus_master.sv
// Z80-timed bus initiator. Turns a req/ack handshake into T1/T2/TW/T3 memory
// cycles with registered mreq_n/rd_n/wr_n strobes, address and write data.
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i, we_i           request and direction, sampled while idle
//   addr_i, wdata_i       request address and write data, latched on accept
//   ack_o, err_o          completion pulse; err_o flags a wait-timeout abort
//   rdata_o               read data, held until the next read completes
//   busy_o                bus cycle in progress
//   a_o, d_out_o, d_oe_o  bus address, write data and its drive enable
//   d_in_i                bus read data
//   mreq_n_o, rd_n_o, wr_n_o  active-low bus strobes
//   wait_n_i              responder wait request, active low
module z80_bus_master
   import z80_bus_master_pkg::*;
#(
   parameter int unsigned ADDR_W     = DefAddrW,
   parameter int unsigned DATA_W     = DefDataW,
   parameter int unsigned TSTATE_DIV = DefTstateDiv,
   parameter int unsigned MAX_WAIT   = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic              ack_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   output logic              busy_o,
   output logic [ADDR_W-1:0] a_o,
   output logic [DATA_W-1:0] d_out_o,
   output logic              d_oe_o,
   input  logic [DATA_W-1:0] d_in_i,
   output logic              mreq_n_o,
   output logic              rd_n_o,
   output logic              wr_n_o,
   input  logic              wait_n_i
);

   localparam int unsigned PhW   = cnt_width(TSTATE_DIV);
   localparam int unsigned WaitW = cnt_width(MAX_WAIT + 1);
   localparam logic [PhW-1:0] HalfM1 = PhW'(TSTATE_DIV / 2 - 1);

   bus_state_e        state_q, state_d;
   logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic              we_q;
   logic [ADDR_W-1:0] a_q;
   logic [DATA_W-1:0] wdata_q, d_out_q, rdata_q;
   logic              d_oe_q, mreq_n_q, rd_n_q, wr_n_q, ack_q, err_q, busy_q;

   logic [PhW-1:0] phase;
   logic           half, last, accept, wait_done;
   logic           t1_late, mreq_lo_d, wr_lo_d, d_oe_d, ack_d;

   assign accept = (state_q == StIdle) && req_i;

   z80_bus_master_timer #(
      .Div (TSTATE_DIV),
      .PhW (PhW)
   ) u_timer (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clr_i   (accept),
      .en_i    (state_q != StIdle),
      .phase_o (phase),
      .half_o  (half),
      .last_o  (last)
   );

   // This TW is the MAX_WAIT-th one to complete.
   assign wait_done = (32'(wait_cnt_q) + 32'd1) >= MAX_WAIT;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      unique case (state_q)
         StIdle: begin
            if (req_i) begin
               state_d    = StT1;
               wait_cnt_d = '0;
               timeout_d  = 1'b0;
            end
         end
         StT1: if (last) state_d = StT2;
         StT2: if (last) state_d = wait_n_i ? StT3 : StTw;
         StTw: begin
            if (last) begin
               wait_cnt_d = wait_cnt_q + WaitW'(1);
               if (wait_n_i) begin
                  state_d = StT3;
               end else if ((MAX_WAIT != 0) && wait_done) begin
                  state_d   = StT3;
                  timeout_d = 1'b1;
               end
            end
         end
         StT3: if (last) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Strobes are registered, so decode where the *next* clk falls in the cycle.
   always_comb begin
      t1_late   = (state_q == StT1) && (half || (phase == HalfM1));
      mreq_lo_d = t1_late || (state_q == StT2) || (state_q == StTw) ||
                  ((state_q == StT3) && !last);
      // wr_n releases one clk before mreq_n: next phase must be <= D-2.
      wr_lo_d   = we_q && (((state_q == StT1) && last) || (state_q == StT2) ||
                  (state_q == StTw) ||
                  ((state_q == StT3) && ((32'(phase) + 32'd3) <= TSTATE_DIV)));
      // Write data is held through the ack cycle.
      d_oe_d    = we_q && (t1_late || (state_q == StT2) || (state_q == StTw) ||
                  (state_q == StT3));
      ack_d     = (state_q == StT3) && last;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
         we_q       <= 1'b0;
         a_q        <= '0;
         wdata_q    <= '0;
         d_out_q    <= '0;
         d_oe_q     <= 1'b0;
         rdata_q    <= '0;
         mreq_n_q   <= StrobeOff;
         rd_n_q     <= StrobeOff;
         wr_n_q     <= StrobeOff;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
         if (accept) begin
            we_q    <= we_i;
            a_q     <= addr_i;
            wdata_q <= wdata_i;
         end
         if (d_oe_d) d_out_q <= wdata_q;
         d_oe_q   <= d_oe_d;
         if (ack_d && !we_q) rdata_q <= d_in_i;
         mreq_n_q <= mreq_lo_d ? StrobeOn : StrobeOff;
         rd_n_q   <= (mreq_lo_d && !we_q) ? StrobeOn : StrobeOff;
         wr_n_q   <= wr_lo_d ? StrobeOn : StrobeOff;
         ack_q    <= ack_d;
         err_q    <= ack_d && timeout_q;
         busy_q   <= (state_d != StIdle);
      end
   end

   assign ack_o    = ack_q;
   assign err_o    = err_q;
   assign rdata_o  = rdata_q;
   assign busy_o   = busy_q;
   assign a_o      = a_q;
   assign d_out_o  = d_out_q;
   assign d_oe_o   = d_oe_q;
   assign mreq_n_o = mreq_n_q;
   assign rd_n_o   = rd_n_q;
   assign wr_n_o   = wr_n_q;

endmodule
